// File: rtl/stim_sweep_gen.sv
// Exhaustive input sweep generator with a 16-bit MISR response compactor.
// Each input vector is held for HOLD cycles; the response is folded in on the last cycle of the hold.
module stim_sweep_gen #(
  parameter int          IN_W  = 6,
  parameter int          OUT_W = 3,
  parameter int          HOLD  = 10,
  parameter logic [15:0] POLY  = 16'h1021,
  parameter logic [15:0] SEED  = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [IN_W-1:0]  vec_out,
  output logic             vec_valid,
  input  logic [OUT_W-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic [IN_W:0]    vec_count,
  output logic [15:0]      signature
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  localparam logic [7:0]    HOLD_LAST = 8'(HOLD - 1);
  localparam logic [IN_W-1:0] VEC_ONE = 1;
  localparam logic [IN_W:0]   CNT_ONE = 1;

  state_t      state;
  logic [7:0]  hold_cnt;
  logic [15:0] resp_ext;
  logic [15:0] sig_next;
  logic        hold_end;
  logic        last_vec;

  always_comb begin
    resp_ext = '0;
    resp_ext[OUT_W-1:0] = resp_in;
    sig_next = {signature[14:0], 1'b0} ^ (signature[15] ? POLY : 16'h0000) ^ resp_ext;
    hold_end = (hold_cnt == HOLD_LAST);
    last_vec = &vec_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      hold_cnt  <= '0;
      vec_out   <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_count <= '0;
      signature <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (abort) begin
            // Results stay readable after an abort; only the level flags drop.
            state     <= S_IDLE;
            vec_out   <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
          end else if (start) begin
            state     <= S_DRIVE;
            hold_cnt  <= '0;
            vec_out   <= '0;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            vec_count <= '0;
            signature <= SEED;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            state     <= S_IDLE;
            vec_out   <= '0;
            vec_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
          end else if (hold_end) begin
            signature <= sig_next;
            vec_count <= vec_count + CNT_ONE;
            if (last_vec) begin
              state     <= S_DONE;
              vec_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              vec_out  <= vec_out + VEC_ONE;
              hold_cnt <= '0;
            end
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
